// File: rtl/branch_ctrl_pkg.sv
// Shared types and helpers for the ID-stage branch controller.
// Holds the FSM state encoding and the register-dependency rule used by the hazard detector.
package branch_ctrl_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_OPND  = 2'd1,
        WAIT_FETCH = 2'd2
    } state_t;

    // $0 is hard-wired zero, so it never depends on an in-flight load.
    function automatic logic reg_match(
        input logic              rd,
        input logic [REG_AW-1:0] src,
        input logic              load,
        input logic [REG_AW-1:0] dst
    );
        return rd && load && (src != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/load_hazard_det.sv
// Load-use hazard comparison for the branch operands in ID.
// ex_hz: an operand is produced by a load in EX; mem_hz: by a load in MEM.
module load_hazard_det
    import branch_ctrl_pkg::*;
(
    input  logic              rs_read,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic              rt_read,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic              ex_load,
    input  logic [REG_AW-1:0] ex_waddr,
    input  logic              mem_load,
    input  logic [REG_AW-1:0] mem_waddr,
    output logic              ex_hz,
    output logic              mem_hz
);

    assign ex_hz  = reg_match(rs_read, rs_addr, ex_load, ex_waddr)
                  | reg_match(rt_read, rt_addr, ex_load, ex_waddr);
    assign mem_hz = reg_match(rs_read, rs_addr, mem_load, mem_waddr)
                  | reg_match(rt_read, rt_addr, mem_load, mem_waddr);

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch controller: stalls branches on load-use hazards, issues PC redirects,
// tracks the delay slot and counts accepted redirects.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_is_branch,
    input  logic              id_rs_read,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic              id_rt_read,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic              ex_load,
    input  logic [REG_AW-1:0] ex_waddr,
    input  logic              mem_load,
    input  logic [REG_AW-1:0] mem_waddr,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic              if_ready,
    input  logic              flush,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              bubble_idex,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_addr,
    output logic              delay_slot,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [1:0]        fsm_state
);

    state_t            state;
    logic              wait_cnt;
    logic [ADDR_W-1:0] latch_addr;
    logic              ds_q;
    logic [CNT_W-1:0]  cnt_q;

    logic ex_hz, mem_hz;
    logic active, eval, hz_entry, resolve, take, hold_opnd, in_fetch, cnt_inc;

    load_hazard_det u_hazard (
        .rs_read   (id_rs_read),
        .rs_addr   (id_rs_addr),
        .rt_read   (id_rt_read),
        .rt_addr   (id_rt_addr),
        .ex_load   (ex_load),
        .ex_waddr  (ex_waddr),
        .mem_load  (mem_load),
        .mem_waddr (mem_waddr),
        .ex_hz     (ex_hz),
        .mem_hz    (mem_hz)
    );

    // A WAIT_OPND cycle whose counter has run out re-evaluates the branch in place, so the
    // stall lasts two cycles behind an EX load and one behind a MEM load.
    // Redirect handshake: a redirect transfers on a cycle with redirect_valid=1 and if_ready=1;
    // once raised, valid holds with a stable address until that cycle or a flush/reset.
    always_comb begin
        active         = !rst && !flush;
        eval           = (state == IDLE) || ((state == WAIT_OPND) && !wait_cnt);
        hz_entry       = active && eval && id_is_branch && (ex_hz || mem_hz);
        resolve        = active && eval && id_is_branch && !(ex_hz || mem_hz);
        take           = resolve && branch_flag;
        hold_opnd      = active && (state == WAIT_OPND) && wait_cnt;
        in_fetch       = active && (state == WAIT_FETCH);
        cnt_inc        = (take && if_ready) || (in_fetch && if_ready);
        stall_pc       = hz_entry || hold_opnd || in_fetch;
        stall_ifid     = hz_entry || hold_opnd || (in_fetch && id_is_branch);
        bubble_idex    = hz_entry || hold_opnd;
        redirect_valid = take || in_fetch;
        redirect_addr  = '0;
        if (take) begin
            redirect_addr = branch_addr;
        end else if (in_fetch) begin
            redirect_addr = latch_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= 1'b0;
            latch_addr <= '0;
            ds_q       <= 1'b0;
            cnt_q      <= '0;
        end else if (flush) begin
            state      <= IDLE;
            wait_cnt   <= 1'b0;
            latch_addr <= '0;
            ds_q       <= 1'b0;
        end else begin
            if (resolve) begin
                ds_q <= 1'b1;
            end else if (!stall_ifid) begin
                ds_q <= 1'b0;
            end
            if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            case (state)
                IDLE, WAIT_OPND: begin
                    if (hz_entry) begin
                        state    <= WAIT_OPND;
                        wait_cnt <= ex_hz;
                    end else if (hold_opnd) begin
                        wait_cnt <= 1'b0;
                    end else if (take && !if_ready) begin
                        state      <= WAIT_FETCH;
                        latch_addr <= branch_addr;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_FETCH: begin
                    if (if_ready) begin
                        state      <= IDLE;
                        latch_addr <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign delay_slot = ds_q;
    assign taken_cnt  = cnt_q;
    assign fsm_state  = state;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed reset/flush checks, then random branches scored against
// expectations derived from the load-use and redirect rules.
module tb_branch_ctrl;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 8;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OPND = 2'd1;
  localparam logic [1:0] ST_FETCH = 2'd2;

  logic clk = 1'b0;
  logic rst, id_is_branch, id_rs_read, id_rt_read, ex_load, mem_load;
  logic [4:0] id_rs_addr, id_rt_addr, ex_waddr, mem_waddr;
  logic branch_flag, if_ready, flush;
  logic [ADDR_W-1:0] branch_addr;
  logic stall_pc, stall_ifid, bubble_idex, redirect_valid, delay_slot;
  logic [ADDR_W-1:0] redirect_addr;
  logic [CNT_W-1:0] taken_cnt;
  logic [1:0] fsm_state;

  branch_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_is_branch(id_is_branch),
    .id_rs_read(id_rs_read), .id_rs_addr(id_rs_addr),
    .id_rt_read(id_rt_read), .id_rt_addr(id_rt_addr),
    .ex_load(ex_load), .ex_waddr(ex_waddr), .mem_load(mem_load), .mem_waddr(mem_waddr),
    .branch_flag(branch_flag), .branch_addr(branch_addr), .if_ready(if_ready), .flush(flush),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_idex(bubble_idex),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .delay_slot(delay_slot), .taken_cnt(taken_cnt), .fsm_state(fsm_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  typedef struct {
    int stalls;
    bit taken;
    logic [ADDR_W-1:0] addr;
    int rc;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  logic [CNT_W-1:0] model_cnt;
  bit mon_en = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // reference: an operand loaded by an instruction in EX costs two cycles, in MEM one
  function automatic int model_stalls(input bit rsr, input logic [4:0] rs, input bit rtr,
                                      input logic [4:0] rt, input bit exl, input logic [4:0] exw,
                                      input bit ml, input logic [4:0] mw);
    bit need_ex, need_mem;
    need_ex  = (rsr && rs != 0 && exl && exw == rs) || (rtr && rt != 0 && exl && exw == rt);
    need_mem = (rsr && rs != 0 && ml && mw == rs) || (rtr && rt != 0 && ml && mw == rt);
    if (need_ex) return 2;
    if (need_mem) return 1;
    return 0;
  endfunction

  function automatic logic [4:0] pick_dst(input logic [4:0] rs, input logic [4:0] rt);
    case ($urandom_range(0, 3))
      0: return rs;
      1: return rt;
      2: return 5'd0;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    id_is_branch = 1'b0;
    id_rs_read = 1'($urandom_range(0, 1));
    id_rs_addr = 5'($urandom_range(0, 31));
    id_rt_read = 1'($urandom_range(0, 1));
    id_rt_addr = 5'($urandom_range(0, 31));
    ex_load = 1'($urandom_range(0, 1));
    ex_waddr = id_rs_addr;
    mem_load = 1'($urandom_range(0, 1));
    mem_waddr = id_rt_addr;
    branch_flag = 1'($urandom_range(0, 1));
    branch_addr = $urandom;
    if_ready = 1'($urandom_range(0, 1));
    tick();
  endtask

  task automatic run_branch(input bit rsr, input logic [4:0] rs, input bit rtr, input logic [4:0] rt,
                            input bit exl, input logic [4:0] exw, input bit ml, input logic [4:0] mw,
                            input bit tk, input logic [ADDR_W-1:0] addr, input int nr);
    exp_t e;
    int st;
    bit done;
    st = model_stalls(rsr, rs, rtr, rt, exl, exw, ml, mw);
    if (tk) model_cnt = model_cnt + 1'b1;
    e.stalls = st;
    e.taken = tk;
    e.addr = addr;
    e.rc = tk ? nr + 1 : 0;
    e.cnt = model_cnt;
    exp_q.push_back(e);
    id_is_branch = 1'b1;
    id_rs_read = rsr; id_rs_addr = rs; id_rt_read = rtr; id_rt_addr = rt;
    ex_load = exl; ex_waddr = exw; mem_load = ml; mem_waddr = mw;
    branch_addr = addr;
    done = 1'b0;
    for (int c = 0; c < 8 && !done; c++) begin
      branch_flag = (c == st) ? tk : 1'($urandom_range(0, 1));
      if_ready = (c == st) ? (nr == 0) : 1'($urandom_range(0, 1));
      @(negedge clk);
      done = !stall_ifid;
      tick();
      if (!done) begin
        // the bubble lets the load move one stage on
        mem_load = ex_load;
        mem_waddr = ex_waddr;
        ex_load = 1'b0;
      end
    end
    id_is_branch = 1'b0;
    ex_load = 1'b0;
    mem_load = 1'b0;
    id_rs_addr = 5'($urandom_range(0, 31));
    id_rt_addr = 5'($urandom_range(0, 31));
    for (int i = 1; i <= (tk ? nr : 0); i++) begin
      if_ready = (i == nr);
      branch_flag = 1'($urandom_range(0, 1));
      tick();
    end
    if_ready = 1'($urandom_range(0, 1));
    tick();
  endtask

  // monitor
  initial begin : monitor
    int phase, st, rc, age, ds_chk;
    exp_t e;
    phase = 0; st = 0; rc = 0; age = 0; ds_chk = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        phase = 0;
        ds_chk = 0;
      end else begin
        if (ds_chk == 2) check("delay_slot_set", 64'(delay_slot), 64'd1);
        else if (ds_chk == 1) check("delay_slot_clr", 64'(delay_slot), 64'd0);
        if (ds_chk > 0) ds_chk--;
        if (phase == 0) begin
          if (id_is_branch) begin
            phase = 1; st = 0; age = 0;
          end else begin
            check("nonbranch_quiet", {stall_pc, stall_ifid, bubble_idex, redirect_valid}, 64'd0);
          end
        end
        if (phase == 1) begin
          age++;
          if (stall_pc && stall_ifid && bubble_idex && !redirect_valid && age < 8) begin
            st++;
          end else if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_branch: got a resolution, expected none queued");
            phase = 0;
          end else begin
            e = exp_q.pop_front();
            check("stall_cycles", st, e.stalls);
            check("redirect_on_resolve", 64'(redirect_valid), 64'(e.taken));
            ds_chk = 2;
            age = 0;
            if (e.taken) begin
              check("redirect_addr", redirect_addr, e.addr);
              rc = 1;
              if (if_ready) begin
                check("redirect_len", rc, e.rc);
                phase = 3;
              end else begin
                phase = 2;
              end
            end else begin
              phase = 3;
            end
          end
        end else if (phase == 2) begin
          age++;
          if (redirect_valid && stall_pc && redirect_addr == e.addr) rc++;
          if (if_ready || age > e.rc + 6) begin
            check("redirect_len", rc, e.rc);
            phase = 3;
          end
        end else if (phase == 3) begin
          check("taken_cnt", taken_cnt, e.cnt);
          phase = 0;
        end
      end
    end
  end

  // main sequence
  initial begin
    logic [4:0] rs, rt;
    rst = 1'b1; flush = 1'b0; id_is_branch = 1'b0;
    id_rs_read = 1'b0; id_rs_addr = 5'd0; id_rt_read = 1'b0; id_rt_addr = 5'd0;
    ex_load = 1'b0; ex_waddr = 5'd0; mem_load = 1'b0; mem_waddr = 5'd0;
    branch_flag = 1'b0; branch_addr = '0; if_ready = 1'b0;
    model_cnt = '0;

    // reset with a taken branch present: nothing may leak out
    id_is_branch = 1'b1; branch_flag = 1'b1; if_ready = 1'b1; branch_addr = 32'h1234_5678;
    id_rs_read = 1'b1; id_rs_addr = 5'd3;
    @(negedge clk);
    check("reset_outputs", {stall_pc, stall_ifid, bubble_idex, redirect_valid, redirect_addr}, 64'd0);
    tick();
    ex_load = 1'b1; ex_waddr = 5'd3;
    @(negedge clk);
    check("reset_outputs_hz", {stall_pc, stall_ifid, bubble_idex, redirect_valid, redirect_addr}, 64'd0);
    tick();
    rst = 1'b0; id_is_branch = 1'b0; ex_load = 1'b0;
    @(negedge clk);
    check("reset_state", {fsm_state, delay_slot, taken_cnt}, 64'd0);

    // flush together with a taken resolution
    tick();
    id_is_branch = 1'b1; branch_flag = 1'b1; if_ready = 1'b1; branch_addr = 32'h0000_0a00; flush = 1'b1;
    @(negedge clk);
    check("flush_resolve_redirect", 64'(redirect_valid), 64'd0);
    tick();
    id_is_branch = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_resolve_state", {fsm_state, delay_slot, taken_cnt}, 64'd0);

    // taken with fetch busy, a branch arriving in WAIT_FETCH, then a flush
    tick();
    id_is_branch = 1'b1; branch_flag = 1'b1; if_ready = 1'b0; branch_addr = 32'h0000_0b40;
    @(negedge clk);
    check("wf_enter_redirect", {redirect_valid, redirect_addr}, {1'b1, 32'h0000_0b40});
    tick();
    branch_addr = 32'h0000_0ccc;
    @(negedge clk);
    check("wf_hold_branch", {stall_pc, stall_ifid, redirect_valid, redirect_addr, fsm_state},
          {3'b111, 32'h0000_0b40, ST_FETCH});
    tick();
    id_is_branch = 1'b0; flush = 1'b1; if_ready = 1'b1;
    @(negedge clk);
    check("wf_flush_redirect", {redirect_valid, redirect_addr}, 64'd0);
    tick();
    flush = 1'b0; if_ready = 1'b0;
    @(negedge clk);
    check("wf_flush_state", {fsm_state, delay_slot, taken_cnt}, 64'd0);

    // one accepted redirect so the counter is non-zero
    tick();
    id_is_branch = 1'b1; branch_flag = 1'b1; if_ready = 1'b1; branch_addr = 32'h0000_0c00;
    @(negedge clk);
    check("direct_redirect", {redirect_valid, redirect_addr}, {1'b1, 32'h0000_0c00});
    tick();
    id_is_branch = 1'b0;
    @(negedge clk);
    check("direct_count", taken_cnt, 64'd1);

    // reset while waiting for an operand
    tick();
    id_is_branch = 1'b1; id_rs_read = 1'b1; id_rs_addr = 5'd9; ex_load = 1'b1; ex_waddr = 5'd9;
    @(negedge clk);
    check("opnd_entry", {stall_pc, stall_ifid, bubble_idex, redirect_valid}, 64'b1110);
    tick();
    ex_load = 1'b0; mem_load = 1'b1; mem_waddr = 5'd9;
    @(negedge clk);
    check("opnd_wait", {fsm_state, stall_pc, stall_ifid, bubble_idex}, {ST_OPND, 3'b111});
    rst = 1'b1;
    #1;
    check("rst_in_opnd", {stall_pc, stall_ifid, bubble_idex, redirect_valid}, 64'd0);
    tick();
    rst = 1'b0; id_is_branch = 1'b0; mem_load = 1'b0;
    @(negedge clk);
    check("rst_opnd_state", {fsm_state, delay_slot, taken_cnt, redirect_valid}, 64'd0);

    // reset while waiting for fetch
    tick();
    id_is_branch = 1'b1; id_rs_read = 1'b0; branch_flag = 1'b1; if_ready = 1'b0; branch_addr = 32'h0000_0d00;
    tick();
    id_is_branch = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_in_fetch", {redirect_valid, stall_pc}, 64'd0);
    tick();
    rst = 1'b0; if_ready = 1'b1;
    @(negedge clk);
    check("rst_fetch_state", {fsm_state, redirect_valid, taken_cnt}, {ST_IDLE, 1'b0, 8'd0});
    tick();

    // scored traffic
    model_cnt = '0;
    mon_en = 1'b1;
    run_branch(1, 5'd5, 1, 5'd6, 1, 5'd5, 0, 5'd0, 0, 32'h0, 0);
    run_branch(1, 5'd7, 1, 5'd3, 0, 5'd0, 1, 5'd7, 1, 32'h0000_2000, 0);
    run_branch(1, 5'd0, 0, 5'd0, 1, 5'd0, 0, 5'd0, 1, 32'h0000_3000, 0);
    run_branch(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 32'h0040_0100, 3);
    run_branch(1, 5'd4, 1, 5'd8, 0, 5'd0, 0, 5'd0, 0, 32'h0, 0);
    for (int n = 0; n < 350; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle_cycle();
      rs = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rt = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      run_branch(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), rt,
                 1'($urandom_range(0, 1)), pick_dst(rs, rt),
                 1'($urandom_range(0, 1)), pick_dst(rs, rt),
                 $urandom_range(0, 4) != 0, $urandom,
                 ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)));
    end
    for (int i = 0; i < 3; i++) idle_cycle();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("pending_expectations", exp_q.size(), 64'd0);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
